// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-side memory responder.
//   Region codes (Memaddr[31:28]), I/O word offsets (Memaddr[7:2]) and TX FIFO depth.
package dmem_pkg;
    localparam logic [3:0] DMEM_RGN_RAM = 4'h0;
    localparam logic [3:0] DMEM_RGN_IO  = 4'h1;

    localparam logic [5:0] IO_LED    = 6'h00;
    localparam logic [5:0] IO_TXDATA = 6'h01;
    localparam logic [5:0] IO_TXSTAT = 6'h02;
    localparam logic [5:0] IO_TCNT   = 6'h03;
    localparam logic [5:0] IO_TCMP   = 6'h04;
    localparam logic [5:0] IO_TCTL   = 6'h05;

    localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: 4-entry first-word-fall-through byte FIFO.
//   clk, reset (async active-low)
//   push_i/push_data_i : enqueue request (dropped when full)
//   pop_i              : dequeue request (ignored when empty)
//   full_o/empty_o/count_o : occupancy status
//   head_o             : oldest byte, 0 when empty
module tx_fifo
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [2:0] count_o,
    output logic [7:0] head_o
);
    logic [7:0] mem_q [FIFO_DEPTH];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       push_ok, pop_ok;

    // Full is judged on the current count, so a push while full is lost even
    // if a pop frees a slot in the same cycle.
    always_comb begin
        full_o   = count_q == 3'(FIFO_DEPTH);
        empty_o  = count_q == '0;
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + 2'(push_ok);
        rd_ptr_d = rd_ptr_q + 2'(pop_ok);
        count_d  = count_q + 3'(push_ok) - 3'(pop_ok);
        count_o  = count_q;
        head_o   = empty_o ? 8'h00 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory responder (data RAM, LED register, TX FIFO, compare timer).
//   clk, reset (async active-low)
//   Memwrite/Memaddr/MemWdata : CPU store/load request; MemRdata : combinational load data
//   led : LED register; tx_valid/tx_data/tx_ready : FIFO drain port
//   timer_irq : sticky timer match flag
//   Optional macro DMEM_TIMER_EN builds the timer; otherwise its registers read 0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS = 2048,
    parameter int LED_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Memwrite,
    input  logic [31:0]      Memaddr,
    input  logic [31:0]      MemWdata,
    output logic [31:0]      MemRdata,
    output logic [LED_W-1:0] led,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             timer_irq
);
    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]      ram [RAM_WORDS];
    logic [AW-1:0]    ram_idx;
    logic [5:0]       io_off;
    logic             rgn_ram, rgn_io, ram_wr, io_wr;
    logic [LED_W-1:0] led_q, led_d;
    logic             fifo_full, fifo_empty;
    logic [2:0]       fifo_count;
    logic [31:0]      tcnt_rd, tcmp_rd, tctl_rd;
    logic             unused_addr;

    assign unused_addr = ^Memaddr;

    always_comb begin
        ram_idx = Memaddr[AW+1:2];
        io_off  = Memaddr[7:2];
        rgn_ram = Memaddr[31:28] == DMEM_RGN_RAM;
        rgn_io  = Memaddr[31:28] == DMEM_RGN_IO;
        ram_wr  = Memwrite && rgn_ram;
        io_wr   = Memwrite && rgn_io;
        led_d   = (io_wr && io_off == IO_LED) ? MemWdata[LED_W-1:0] : led_q;
    end

    always_ff @(posedge clk) begin
        if (ram_wr) ram[ram_idx] <= MemWdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) led_q <= '0;
        else        led_q <= led_d;
    end

    assign led = led_q;

    tx_fifo u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (io_wr && io_off == IO_TXDATA),
        .push_data_i (MemWdata[7:0]),
        .pop_i       (tx_valid && tx_ready),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .head_o      (tx_data)
    );

    assign tx_valid = !fifo_empty;

`ifdef DMEM_TIMER_EN
    logic [31:0] cnt_q, cnt_d, cmp_q, cmp_d;
    logic        en_q, en_d, flag_q, flag_d, wr_cnt, wr_cmp, wr_ctl;

    // A CPU write to the counter overrides the increment; a match set
    // outranks a same-cycle write-1-to-clear of the flag.
    always_comb begin
        wr_cnt = io_wr && io_off == IO_TCNT;
        wr_cmp = io_wr && io_off == IO_TCMP;
        wr_ctl = io_wr && io_off == IO_TCTL;
        cnt_d  = wr_cnt ? MemWdata : en_q ? cnt_q + 32'd1 : cnt_q;
        cmp_d  = wr_cmp ? MemWdata : cmp_q;
        en_d   = wr_ctl ? MemWdata[1] : en_q;
        flag_d = (en_q && cnt_q == cmp_q) ? 1'b1 : (wr_ctl && MemWdata[0]) ? 1'b0 : flag_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            cmp_q  <= '1;
            en_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cmp_q  <= cmp_d;
            en_q   <= en_d;
            flag_q <= flag_d;
        end
    end

    assign tcnt_rd   = cnt_q;
    assign tcmp_rd   = cmp_q;
    assign tctl_rd   = {30'd0, en_q, flag_q};
    assign timer_irq = flag_q;
`else
    assign tcnt_rd   = '0;
    assign tcmp_rd   = '0;
    assign tctl_rd   = '0;
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        MemRdata = '0;
        if (rgn_ram) begin
            MemRdata = ram[ram_idx];
        end else if (rgn_io) begin
            case (io_off)
                IO_LED:    MemRdata = 32'(led_q);
                IO_TXSTAT: MemRdata = {27'd0, fifo_count, fifo_empty, fifo_full};
                IO_TCNT:   MemRdata = tcnt_rd;
                IO_TCMP:   MemRdata = tcmp_rd;
                IO_TCTL:   MemRdata = tctl_rd;
                default:   MemRdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Memwrite = 1'b0;
    logic [31:0] Memaddr = '0;
    logic [31:0] MemWdata = '0;
    logic [31:0] MemRdata;
    logic [7:0]  led;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A_LED  = 32'h1000_0000;
    localparam logic [31:0] A_TXD  = 32'h1000_0004;
    localparam logic [31:0] A_STAT = 32'h1000_0008;
    localparam logic [31:0] A_TCNT = 32'h1000_000C;
    localparam logic [31:0] A_TCMP = 32'h1000_0010;
    localparam logic [31:0] A_TCTL = 32'h1000_0014;

    dmem_responder #(.RAM_WORDS(2048), .LED_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .Memwrite  (Memwrite),
        .Memaddr   (Memaddr),
        .MemWdata  (MemWdata),
        .MemRdata  (MemRdata),
        .led       (led),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Memwrite = 1'b1;
        Memaddr  = a;
        MemWdata = d;
        @(posedge clk);
        #1 Memwrite = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        Memwrite = 1'b0;
        Memaddr  = a;
        #1 chk(name, MemRdata, exp);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_led;
        string       name;
    } vec_t;

    vec_t vecs[14];
    logic [7:0] drain[4];

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 8'h00, "ram_wr"};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 8'h00, "ram_rd"};
        vecs[2]  = '{1'b0, 32'h0000_2010, 32'h0, 32'hDEAD_BEEF, 8'h00, "ram_alias"};
        vecs[3]  = '{1'b1, 32'h0000_0014, 32'h0BAD_F00D, 32'h0, 8'h00, "ram_wr2"};
        vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0, 32'h0BAD_F00D, 8'h00, "ram_rd2"};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 8'h00, "ram_keep"};
        vecs[6]  = '{1'b1, A_LED, 32'hFFFF_FFA5, 32'h0, 8'hA5, "led_wr"};
        vecs[7]  = '{1'b0, A_LED, 32'h0, 32'h0000_00A5, 8'hA5, "led_rd"};
        vecs[8]  = '{1'b0, 32'h2000_0000, 32'h0, 32'h0, 8'hA5, "unmapped_rd"};
        vecs[9]  = '{1'b1, 32'h2000_0000, 32'h1234_5678, 32'h0, 8'hA5, "unmapped_wr"};
        vecs[10] = '{1'b1, 32'h1000_0040, 32'h0000_00FF, 32'h0, 8'hA5, "io_hole_wr"};
        vecs[11] = '{1'b0, 32'h1000_0040, 32'h0, 32'h0, 8'hA5, "io_hole_rd"};
        vecs[12] = '{1'b0, A_TXD, 32'h0, 32'h0, 8'hA5, "txdata_rd"};
        vecs[13] = '{1'b0, A_STAT, 32'h0, 32'h0000_0002, 8'hA5, "stat_empty"};
        drain = '{8'h11, 8'h22, 8'h33, 8'h44};

        #12;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_valid", 32'(tx_valid), 32'h0);
        chk("rst_data", 32'(tx_data), 32'h0);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            Memwrite = vecs[i].we;
            Memaddr  = vecs[i].addr;
            MemWdata = vecs[i].wdata;
            #1 if (!vecs[i].we) chk(vecs[i].name, MemRdata, vecs[i].exp_rd);
            @(posedge clk);
            #1 chk({vecs[i].name, "_led"}, 32'(led), 32'(vecs[i].exp_led));
            Memwrite = 1'b0;
        end

        // Fill past capacity: 0x55 must be dropped.
        for (int i = 1; i <= 5; i++) wr(A_TXD, 32'(8'h11 * i));
        rd("stat_full", A_STAT, 32'h11);
        chk("head_full", 32'(tx_data), 32'h11);
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), 32'(tx_data), 32'(drain[i]));
            @(negedge clk);
        end
        tx_ready = 1'b0;
        chk("drained_valid", 32'(tx_valid), 32'h0);
        rd("stat_drained", A_STAT, 32'h02);

        // Push and pop together at count 2.
        wr(A_TXD, 32'h77);
        wr(A_TXD, 32'h88);
        @(negedge clk);
        Memwrite = 1'b1;
        Memaddr  = A_TXD;
        MemWdata = 32'h66;
        tx_ready = 1'b1;
        @(negedge clk);
        Memwrite = 1'b0;
        tx_ready = 1'b0;
        Memaddr  = A_STAT;
        #1 chk("pushpop_stat", MemRdata, 32'h08);
        chk("pushpop_head", 32'(tx_data), 32'h88);
        @(negedge clk);
        tx_ready = 1'b1;
        #1 chk("pushpop_next", 32'(tx_data), 32'h88);
        @(negedge clk);
        #1 chk("pushpop_last", 32'(tx_data), 32'h66);
        @(negedge clk);
        tx_ready = 1'b0;
        #1 chk("pushpop_empty", 32'(tx_valid), 32'h0);

`ifdef DMEM_TIMER_EN
        rd("tcmp_rst", A_TCMP, 32'hFFFF_FFFF);
        wr(A_TCMP, 32'd5);
        wr(A_TCNT, 32'd0);
        wr(A_TCTL, 32'h2);
        repeat (5) @(posedge clk);
        #1 chk("irq_before", 32'(timer_irq), 32'h0);
        @(posedge clk);
        #1 chk("irq_match", 32'(timer_irq), 32'h1);
        Memaddr = A_TCNT;
        #1 chk("tcnt_match", MemRdata, 32'd6);
        rd("tctl_set", A_TCTL, 32'h3);
        wr(A_TCTL, 32'h3);
        chk("irq_cleared", 32'(timer_irq), 32'h0);
        Memaddr = A_TCTL;
        #1 chk("tctl_cleared", MemRdata, 32'h2);
        wr(A_TCNT, 32'hFFFF_FFFE);
        @(posedge clk);
        #1 chk("tcnt_max", MemRdata, 32'hFFFF_FFFF);
        @(posedge clk);
        #1 chk("tcnt_wrap", MemRdata, 32'h0);
        wr(A_TCNT, 32'd4);
        @(posedge clk);
        #1 chk("irq_pre_set", 32'(timer_irq), 32'h0);
        wr(A_TCTL, 32'h3);
        chk("irq_set_wins", 32'(timer_irq), 32'h1);
`else
        wr(A_TCMP, 32'd5);
        wr(A_TCNT, 32'd7);
        wr(A_TCTL, 32'h3);
        rd("tcnt_off", A_TCNT, 32'h0);
        rd("tcmp_off", A_TCMP, 32'h0);
        rd("tctl_off", A_TCTL, 32'h0);
        repeat (10) @(posedge clk);
        #1 chk("irq_off", 32'(timer_irq), 32'h0);
`endif

        // Asynchronous reset with three bytes queued.
        wr(A_TXD, 32'hA1);
        wr(A_TXD, 32'hA2);
        wr(A_TXD, 32'hA3);
        rd("stat_three", A_STAT, 32'h0C);
        chk("led_pre_rst", 32'(led), 32'hA5);
        #2 reset = 1'b0;
        #1 chk("arst_valid", 32'(tx_valid), 32'h0);
        chk("arst_led", 32'(led), 32'h0);
        chk("arst_data", 32'(tx_data), 32'h0);
        chk("arst_stat", MemRdata, 32'h02);
        @(negedge clk);
        reset = 1'b1;
        rd("post_rst_ram", 32'h0000_0010, 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
